// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux; drives grant, S1/S0 select and gnt_valid. Optional lock input via MUX4_ARB_LOCK_EN.
// Latency: 1 cycle from req to grant; a GAP cycle plus an IDLE cycle separate consecutive grants.
// Backpressure: the owner holds until done, its req drops, or HOLD_MAX expires (timeout pulse).
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
`ifdef MUX4_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] grant,
  output logic       S1,
  output logic       S0,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state, state_nxt;
  logic [1:0]         owner;
  logic [1:0]         last;
  logic [CNT_W-1:0]   hold_cnt;
  logic               timeout_q;

  logic               win_found;
  logic [1:0]         win_idx;
  logic               hold_lim;
  logic               tmo_hit;
  logic               rel;
  logic               tmo_only;

  // Scan last+1, last+2, ... so the previous owner is lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = last + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // >= rather than == so a saturated counter still times out once lock drops.
  assign hold_lim = (hold_cnt >= CNT_W'(HOLD_MAX - 1));
`ifdef MUX4_ARB_LOCK_EN
  assign tmo_hit  = hold_lim && !lock;
`else
  assign tmo_hit  = hold_lim;
`endif
  assign rel      = done || !req[owner] || tmo_hit;
  assign tmo_only = tmo_hit && !done && req[owner];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = GRANT;
      GRANT:   if (rel)       state_nxt = GAP;
      GAP:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      last      <= 2'd3;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      timeout_q <= (state == GRANT) && rel && tmo_only;
      case (state)
        IDLE: begin
          if (win_found) begin
            owner    <= win_idx;
            last     <= win_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (hold_cnt != CNT_W'(HOLD_MAX)) hold_cnt <= hold_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // owner only changes when a grant starts, so the selects hold between grants.
  assign gnt_valid = (state == GRANT);
  assign grant     = gnt_valid ? (4'b0001 << owner) : 4'b0000;
  assign S1        = owner[1];
  assign S0        = owner[0];
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter; the lock scenario runs when MUX4_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
`ifdef MUX4_ARB_LOCK_EN
  logic       lock;
`endif
  logic [3:0] grant;
  logic       S1, S0, gnt_valid, timeout;

  int n_checks = 0;
  int n_errors = 0;

  mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
`ifdef MUX4_ARB_LOCK_EN
    .lock      (lock),
`endif
    .grant     (grant),
    .S1        (S1),
    .S0        (S0),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge; inputs also change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] sel,
                            input logic t);
    check_eq({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    check_eq({tag, ".sel"}, {6'b0, S1, S0}, {6'b0, sel});
    check_eq({tag, ".valid"}, {7'b0, gnt_valid}, {7'b0, (g != 4'b0)});
    check_eq({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
  endtask

  initial begin
    logic [3:0] onehot;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
    lock = 1'b0;
`endif
    tick();
    tick();
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("idle", 4'b0000, 2'd0, 1'b0);
    end

    // Full request set: owners rotate 0,1,2,3,0 with two empty cycles between grants.
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      logic [1:0] k;
      k = 2'(r % 4);
      onehot = 4'b0001 << k;
      tick();
      expect_out("rr.g0", onehot, k, 1'b0);
      tick();
      expect_out("rr.g1", onehot, k, 1'b0);
      tick();
      expect_out("rr.g2", onehot, k, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      if (r == 4) req = 4'b0000;
      expect_out("rr.gap", 4'b0000, k, 1'b0);
      tick();
      expect_out("rr.idle", 4'b0000, k, 1'b0);
    end
    tick();
    expect_out("rr.drain", 4'b0000, 2'd0, 1'b0);

    // Single requester with no done: exactly 8 grant cycles, then a timeout pulse.
    req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out("tmo.hold", 4'b0100, 2'd2, 1'b0);
    end
    tick();
    expect_out("tmo.pulse", 4'b0000, 2'd2, 1'b1);
    tick();
    expect_out("tmo.idle", 4'b0000, 2'd2, 1'b0);
    tick();
    expect_out("tmo.regrant", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("tmo.reqdrop", 4'b0000, 2'd2, 1'b0);
    tick();

    // Owner 1 drops req; with last=1 the scan wraps 2,3,0 so index 0 wins over 1.
    req = 4'b0010;
    tick();
    expect_out("wrap.g1", 4'b0010, 2'd1, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("wrap.nonowner", 4'b0010, 2'd1, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("wrap.gap", 4'b0000, 2'd1, 1'b0);
    req = 4'b0011;
    tick();
    expect_out("wrap.idle", 4'b0000, 2'd1, 1'b0);
    tick();
    expect_out("wrap.g0", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    tick();

    // done in the cycle the hold limit is reached is a normal release.
    req = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out("dlim.hold", 4'b1000, 2'd3, 1'b0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    expect_out("dlim.rel", 4'b0000, 2'd3, 1'b0);
    tick();

    // Reset on the third cycle of a grant to index 2 restores last=3.
    req = 4'b0100;
    tick();
    expect_out("rst.g2a", 4'b0100, 2'd2, 1'b0);
    tick();
    tick();
    expect_out("rst.g2c", 4'b0100, 2'd2, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("rst.mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b0101;
    tick();
    expect_out("rst.first", 4'b0001, 2'd0, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("rst.mid2", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    expect_out("rst.last3", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("rst.gap", 4'b0000, 2'd0, 1'b0);
    tick();

`ifdef MUX4_ARB_LOCK_EN
    // Lock suppresses the timeout; dropping it after saturation forces release.
    lock = 1'b1;
    req  = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("lock.hold", 4'b0001, 2'd0, 1'b0);
    end
    lock = 1'b0;
    tick();
    expect_out("lock.rel", 4'b0000, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("lock.idle", 4'b0000, 2'd0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
